// File: rtl/pipeline_run_ctrl_pkg.sv
// Shared definitions for the pipeline run controller: FSM state encodings and
// debug command codes, also used by the CPU top and the testbench.
package pipeline_run_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_HALTED   = 2'b00,
    ST_RUNNING  = 2'b01,
    ST_STEPPING = 2'b10
  } run_state_e;

  typedef enum logic [1:0] {
    OP_NOP  = 2'b00,
    OP_RUN  = 2'b01,
    OP_HALT = 2'b10,
    OP_STEP = 2'b11
  } cmd_op_e;

  localparam int unsigned RUN_CNT_W = 32;

endpackage

// File: rtl/run_cycle_counter.sv
// Free-running cycle counter with enable and asynchronous clear; wraps at 2^32.
module run_cycle_counter
  import pipeline_run_ctrl_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  output logic [RUN_CNT_W-1:0] count_o
);

  logic [RUN_CNT_W-1:0] count_q;

  // NOTE: sequential state is always written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (en_i) begin
      count_q <= count_q + RUN_CNT_W'(1);
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// Debug run/halt/step controller for the CPU pipeline with a single PC breakpoint.
// run_stall is combinational so a breakpoint stops the fetch of bp_addr itself.
module pipeline_run_ctrl
  import pipeline_run_ctrl_pkg::*;
#(
  parameter logic        RESET_RUN = 1'b1,
  parameter int unsigned STEP_W    = 8
) (
  input  logic                 Clock,
  input  logic                 Resetn,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [STEP_W-1:0]    cmd_arg,
  output logic                 cmd_ready,
  input  logic                 bp_en,
  input  logic [31:0]          bp_addr,
  input  logic [31:0]          PC,
  output logic                 run_stall,
  output logic                 halted,
  output logic                 bp_hit,
  output logic                 step_done,
  output logic [RUN_CNT_W-1:0] run_cycles
);

  localparam run_state_e        RESET_STATE = RESET_RUN ? ST_RUNNING : ST_HALTED;
  localparam logic [STEP_W-1:0] STEP_ONE    = STEP_W'(1);

  run_state_e        state_q, state_d;
  logic [STEP_W-1:0] step_cnt_q, step_cnt_d;
  logic              bp_skip_q, bp_skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic              step_done_q, step_done_d;
  logic              halted_q, halted_d;
  logic              match;
  logic              cmd_accept;
  cmd_op_e           op;

  assign op         = cmd_op_e'(cmd_op);
  assign match      = bp_en && (PC == bp_addr) && !bp_skip_q;
  assign run_stall  = (state_q == ST_HALTED) || match;
  assign cmd_ready  = (state_q != ST_STEPPING);
  assign cmd_accept = cmd_valid && cmd_ready;

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    bp_skip_d   = bp_skip_q;
    bp_hit_d    = bp_hit_q;
    step_done_d = 1'b0;

    if (!run_stall) begin
      bp_skip_d = 1'b0;
    end

    case (state_q)
      ST_HALTED: begin
        // Leaving HALTED arms the skip so a resume at bp_addr executes it once.
        if (cmd_accept && op == OP_RUN) begin
          state_d   = ST_RUNNING;
          bp_hit_d  = 1'b0;
          bp_skip_d = 1'b1;
        end else if (cmd_accept && op == OP_STEP) begin
          state_d    = ST_STEPPING;
          step_cnt_d = (cmd_arg == '0) ? STEP_ONE : cmd_arg;
          bp_hit_d   = 1'b0;
          bp_skip_d  = 1'b1;
        end
      end
      ST_RUNNING: begin
        if (match) begin
          state_d  = ST_HALTED;
          bp_hit_d = 1'b1;
        end else if (cmd_accept && op == OP_HALT) begin
          state_d = ST_HALTED;
        end
      end
      ST_STEPPING: begin
        // Without a match run_stall is low here, so each cycle retires one step.
        if (match) begin
          state_d    = ST_HALTED;
          bp_hit_d   = 1'b1;
          step_cnt_d = '0;
        end else if (step_cnt_q == STEP_ONE) begin
          state_d     = ST_HALTED;
          step_cnt_d  = '0;
          step_done_d = 1'b1;
        end else begin
          step_cnt_d = step_cnt_q - STEP_ONE;
        end
      end
      default: state_d = ST_HALTED;
    endcase

    halted_d = (state_d == ST_HALTED);
  end

  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q     <= RESET_STATE;
      step_cnt_q  <= '0;
      bp_skip_q   <= 1'b1;
      bp_hit_q    <= 1'b0;
      step_done_q <= 1'b0;
      halted_q    <= (RESET_STATE == ST_HALTED);
    end else begin
      state_q     <= state_d;
      step_cnt_q  <= step_cnt_d;
      bp_skip_q   <= bp_skip_d;
      bp_hit_q    <= bp_hit_d;
      step_done_q <= step_done_d;
      halted_q    <= halted_d;
    end
  end

  assign halted    = halted_q;
  assign bp_hit    = bp_hit_q;
  assign step_done = step_done_q;

  run_cycle_counter u_run_cnt (
    .clk     (Clock),
    .rst_n   (Resetn),
    .en_i    (!run_stall),
    .count_o (run_cycles)
  );

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
// Directed bench for pipeline_run_ctrl: a vector table for step/breakpoint/run
// flows plus hand sequences for held commands, HALT-vs-match, reset and wrap.
module tb_pipeline_run_ctrl;
  import pipeline_run_ctrl_pkg::*;

  logic        Clock = 1'b0;
  logic        Resetn;
  logic        cmd_valid;
  logic [1:0]  cmd_op;
  logic [7:0]  cmd_arg;
  logic        cmd_ready;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] PC;
  logic        run_stall;
  logic        halted;
  logic        bp_hit;
  logic        step_done;
  logic [31:0] run_cycles;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [1:0]  op;
    logic [7:0]  arg;
    logic        be;
    logic [31:0] ba;
    logic        stall;
    logic        ready;
    logic        hlt;
    logic        hit;
    logic        done;
    logic [31:0] rc;
    logic [31:0] pc;
  } vec_t;

  vec_t vq[$];

  always #5 Clock = ~Clock;

  pipeline_run_ctrl #(.RESET_RUN(1'b0), .STEP_W(8)) dut (
    .Clock      (Clock),
    .Resetn     (Resetn),
    .cmd_valid  (cmd_valid),
    .cmd_op     (cmd_op),
    .cmd_arg    (cmd_arg),
    .cmd_ready  (cmd_ready),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .PC         (PC),
    .run_stall  (run_stall),
    .halted     (halted),
    .bp_hit     (bp_hit),
    .step_done  (step_done),
    .run_cycles (run_cycles)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One clock; the bench plays the PC register, advancing by 4 when not stalled.
  task automatic tick();
    logic s;
    s = run_stall;
    @(posedge Clock);
    #1;
    if (!s) PC = PC + 32'd4;
  endtask

  task automatic add(input logic v, input logic [1:0] op, input logic [7:0] arg,
                     input logic be, input logic [31:0] ba,
                     input logic st, input logic rdy, input logic hl, input logic hit,
                     input logic dn, input logic [31:0] rc, input logic [31:0] pc);
    vec_t t;
    t.valid = v;  t.op = op;    t.arg = arg; t.be = be;   t.ba = ba;
    t.stall = st; t.ready = rdy; t.hlt = hl; t.hit = hit; t.done = dn;
    t.rc = rc;    t.pc = pc;
    vq.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] bp_pc;

    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_arg = '0;
    bp_en = 1'b0; bp_addr = '0; PC = '0;
    Resetn = 1'b1;
    #2 Resetn = 1'b0;
    #1;
    check("rst.halted",     32'(halted),    32'd1);
    check("rst.run_stall",  32'(run_stall), 32'd1);
    check("rst.cmd_ready",  32'(cmd_ready), 32'd1);
    check("rst.bp_hit",     32'(bp_hit),    32'd0);
    check("rst.step_done",  32'(step_done), 32'd0);
    check("rst.run_cycles", run_cycles,     32'd0);
    @(posedge Clock); #1;
    repeat (2) tick();
    Resetn = 1'b1;

    //  v  op       arg be ba      st rdy hl hit dn  rc     pc
    add(0, OP_NOP,  0, 0, 32'h00, 1, 1, 1, 0, 0, 32'd0,  32'h00);
    add(1, OP_STEP, 3, 0, 32'h00, 1, 1, 1, 0, 0, 32'd0,  32'h00);
    add(0, OP_NOP,  0, 0, 32'h00, 0, 0, 0, 0, 0, 32'd0,  32'h00);
    add(0, OP_NOP,  0, 0, 32'h00, 0, 0, 0, 0, 0, 32'd1,  32'h04);
    add(0, OP_NOP,  0, 0, 32'h00, 0, 0, 0, 0, 0, 32'd2,  32'h08);
    add(0, OP_NOP,  0, 0, 32'h00, 1, 1, 1, 0, 1, 32'd3,  32'h0C);
    add(0, OP_NOP,  0, 0, 32'h00, 1, 1, 1, 0, 0, 32'd3,  32'h0C);
    add(1, OP_RUN,  0, 1, 32'h10, 1, 1, 1, 0, 0, 32'd3,  32'h0C);
    add(0, OP_NOP,  0, 1, 32'h10, 0, 1, 0, 0, 0, 32'd3,  32'h0C);
    add(0, OP_NOP,  0, 1, 32'h10, 1, 1, 0, 0, 0, 32'd4,  32'h10);
    add(0, OP_NOP,  0, 1, 32'h10, 1, 1, 1, 1, 0, 32'd4,  32'h10);
    add(0, OP_NOP,  0, 1, 32'h10, 1, 1, 1, 1, 0, 32'd4,  32'h10);
    add(1, OP_RUN,  0, 1, 32'h10, 1, 1, 1, 1, 0, 32'd4,  32'h10);
    add(0, OP_NOP,  0, 1, 32'h10, 0, 1, 0, 0, 0, 32'd4,  32'h10);
    add(0, OP_NOP,  0, 1, 32'h10, 0, 1, 0, 0, 0, 32'd5,  32'h14);
    add(1, OP_HALT, 0, 1, 32'h10, 0, 1, 0, 0, 0, 32'd6,  32'h18);
    add(0, OP_NOP,  0, 1, 32'h10, 1, 1, 1, 0, 0, 32'd7,  32'h1C);
    add(1, OP_STEP, 0, 1, 32'h10, 1, 1, 1, 0, 0, 32'd7,  32'h1C);
    add(0, OP_NOP,  0, 1, 32'h10, 0, 0, 0, 0, 0, 32'd7,  32'h1C);
    add(0, OP_NOP,  0, 1, 32'h10, 1, 1, 1, 0, 1, 32'd8,  32'h20);
    add(1, OP_STEP, 5, 1, 32'h28, 1, 1, 1, 0, 0, 32'd8,  32'h20);
    add(0, OP_NOP,  0, 1, 32'h28, 0, 0, 0, 0, 0, 32'd8,  32'h20);
    add(0, OP_NOP,  0, 1, 32'h28, 0, 0, 0, 0, 0, 32'd9,  32'h24);
    add(0, OP_NOP,  0, 1, 32'h28, 1, 0, 0, 0, 0, 32'd10, 32'h28);
    add(0, OP_NOP,  0, 1, 32'h28, 1, 1, 1, 1, 0, 32'd10, 32'h28);
    add(0, OP_NOP,  0, 1, 32'h28, 1, 1, 1, 1, 0, 32'd10, 32'h28);

    foreach (vq[i]) begin
      cmd_valid = vq[i].valid; cmd_op = vq[i].op; cmd_arg = vq[i].arg;
      bp_en = vq[i].be; bp_addr = vq[i].ba;
      #1;
      check($sformatf("v%0d.run_stall", i),  32'(run_stall), 32'(vq[i].stall));
      check($sformatf("v%0d.cmd_ready", i),  32'(cmd_ready), 32'(vq[i].ready));
      check($sformatf("v%0d.halted", i),     32'(halted),    32'(vq[i].hlt));
      check($sformatf("v%0d.bp_hit", i),     32'(bp_hit),    32'(vq[i].hit));
      check($sformatf("v%0d.step_done", i),  32'(step_done), 32'(vq[i].done));
      check($sformatf("v%0d.run_cycles", i), run_cycles,     vq[i].rc);
      check($sformatf("v%0d.pc", i),         PC,             vq[i].pc);
      tick();
    end

    // Command held valid while STEPPING is refused until the controller halts.
    bp_en = 1'b0; cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 8'd2;
    #1 check("hold.ready_halted", 32'(cmd_ready), 32'd1);
    tick();
    cmd_op = OP_RUN;
    #1;
    check("hold.ready_step1", 32'(cmd_ready), 32'd0);
    check("hold.halted_step1", 32'(halted), 32'd0);
    tick();
    #1 check("hold.ready_step2", 32'(cmd_ready), 32'd0);
    tick();
    #1;
    check("hold.halted_end", 32'(halted),    32'd1);
    check("hold.ready_end",  32'(cmd_ready), 32'd1);
    check("hold.step_done",  32'(step_done), 32'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("hold.run_accepted", 32'(halted), 32'd0);
    check("hold.run_stall",    32'(run_stall), 32'd0);
    check("hold.pc",           PC, 32'h30);

    // HALT and a breakpoint match on the same cycle: the match wins and flags.
    bp_pc = PC + 32'd4;
    bp_en = 1'b1; bp_addr = bp_pc;
    #1 tick();
    cmd_valid = 1'b1; cmd_op = OP_HALT;
    #1;
    check("halt_bp.run_stall", 32'(run_stall), 32'd1);
    tick();
    cmd_valid = 1'b0;
    #1;
    check("halt_bp.halted", 32'(halted), 32'd1);
    check("halt_bp.bp_hit", 32'(bp_hit), 32'd1);
    check("halt_bp.pc",     PC,          bp_pc);

    // Reset asserted in the middle of a STEP sequence.
    bp_en = 1'b0; cmd_valid = 1'b1; cmd_op = OP_STEP; cmd_arg = 8'd4;
    tick();
    cmd_valid = 1'b0;
    tick();
    #1 check("midrst.stepping", 32'(halted), 32'd0);
    #2 Resetn = 1'b0;
    #1;
    check("midrst.halted",     32'(halted),    32'd1);
    check("midrst.run_stall",  32'(run_stall), 32'd1);
    check("midrst.cmd_ready",  32'(cmd_ready), 32'd1);
    check("midrst.bp_hit",     32'(bp_hit),    32'd0);
    check("midrst.step_done",  32'(step_done), 32'd0);
    check("midrst.run_cycles", run_cycles,     32'd0);
    tick(); tick();
    Resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("postrst%0d.step_done", k), 32'(step_done), 32'd0);
      check($sformatf("postrst%0d.halted", k),    32'(halted),    32'd1);
      tick();
    end

    // run_cycles preset to all ones wraps to zero on the next running cycle.
    force dut.u_run_cnt.count_q = 32'hFFFF_FFFF;
    #1 release dut.u_run_cnt.count_q;
    #1 check("wrap.preset", run_cycles, 32'hFFFF_FFFF);
    cmd_valid = 1'b1; cmd_op = OP_RUN;
    tick();
    cmd_valid = 1'b0;
    #1;
    check("wrap.hold_while_halted", run_cycles, 32'hFFFF_FFFF);
    check("wrap.run_stall", 32'(run_stall), 32'd0);
    tick();
    #1 check("wrap.zero", run_cycles, 32'd0);
    tick();
    #1 check("wrap.one", run_cycles, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
